// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 14-bit binary to 4-digit packed BCD converter.
// Double-dabble with one shift per cycle. Inputs above 9999 saturate
// the display value to 9999 and raise ovf.

// One BCD digit of the double-dabble correction: add 3 when digit >= 5.
module bin2bcd_seq_dab (
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);
   assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bin2bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd,
   output logic             ovf
);
   // Five scratch digits: 14 bits reach 16383, so a fifth digit is
   // needed to hold the intermediate value even though only four are shown.
   localparam int DIG   = 5;
   localparam int SCR_W = DIG*4;
   localparam logic [3:0]       LAST_CNT = 4'(BIN_W-1);
   localparam logic [BIN_W-1:0] MAX_DEC  = BIN_W'(9999);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q;
   logic [BIN_W-1:0]     shift_q, shift_d;
   logic [DIG-1:0][3:0]  scr_q, scr_adj;
   logic [SCR_W-1:0]     scr_d;
   logic [SCR_W:0]       shl;
   logic [3:0]           cnt_q;
   logic                 ovf_pend_q;
   logic                 busy_q, done_q, ovf_q;
   logic [15:0]          bcd_q;
   logic                 unused_shl_msb;

   // Per-digit add-3 correction, all digits in parallel.
   for (genvar g = 0; g < DIG; g++) begin : g_dab
      bin2bcd_seq_dab u_dab (
         .dig_i (scr_q[g]),
         .dig_o (scr_adj[g])
      );
   end

   // Shift {scratch, shift_reg} left one bit after correction. The bit
   // shifted out of the scratch top is always zero for 14-bit inputs.
   assign shl            = {scr_adj, shift_q[BIN_W-1]};
   assign scr_d          = shl[SCR_W-1:0];
   assign shift_d        = {shift_q[BIN_W-2:0], 1'b0};
   assign unused_shl_msb = shl[SCR_W];

   // Control FSM with registered outputs; done is a one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         scr_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  shift_q    <= bin;
                  scr_q      <= '0;
                  cnt_q      <= '0;
                  ovf_pend_q <= (bin > MAX_DEC);
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               shift_q <= shift_d;
               scr_q   <= scr_d;
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == LAST_CNT) begin
                  bcd_q   <= ovf_pend_q ? 16'h9999 : scr_d[15:0];
                  ovf_q   <= ovf_pend_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal
// arithmetic reference model.
module tb_bin2bcd_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        busy, done, ovf;
   logic [15:0] bcd;

   int n_tests = 0;
   int n_fail  = 0;

   bin2bcd_seq #(.BIN_W(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits by division, saturate above 9999.
   function automatic logic [15:0] ref_bcd(input int v);
      if (v > 9999) return 16'h9999;
      return {4'((v/1000)%10), 4'((v/100)%10), 4'((v/10)%10), 4'(v%10)};
   endfunction

   // Issue start with value v in the current (idle or done) cycle, then
   // follow the conversion. poke > 0 re-asserts start with bin=42 at that
   // busy cycle, which must be ignored. Returns at the sample after done.
   task automatic convert(input int v, input int poke);
      int lat = -1;
      int busy_cnt = 0;
      logic hold_ok = 1'b1;
      logic [15:0] prev_bcd = bcd;
      logic prev_ovf = ovf;
      logic [15:0] exp_b;
      logic dig_ok;
      start = 1'b1;
      bin   = 14'(v);
      @(posedge clk); #1;
      start = 1'b0;
      bin   = 14'($urandom_range(0, 16383));
      for (int cyc = 0; cyc <= 20; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         start = 1'b0;
         if (cyc == poke && poke > 0) begin
            start = 1'b1;
            bin   = 14'd42;
         end
         if (busy) busy_cnt++;
         if (done) begin
            lat = cyc;
            break;
         end
         if (bcd !== prev_bcd || ovf !== prev_ovf) hold_ok = 1'b0;
      end
      start = 1'b0;
      exp_b = ref_bcd(v);
      chk("latency", 32'(lat), 32'd14);
      chk("busy_cycles", 32'(busy_cnt), 32'd14);
      chk("hold", 32'(hold_ok), 32'd1);
      chk("bcd", 32'(bcd), 32'(exp_b));
      chk("ovf", 32'(ovf), 32'(v > 9999));
      dig_ok = 1'b1;
      for (int d = 0; d < 4; d++) if (bcd[d*4 +: 4] > 4'd9) dig_ok = 1'b0;
      chk("digit_le9", 32'(dig_ok), 32'd1);
   endtask

   initial begin
      int seen_done;
      // Power-up reset state.
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_done", 32'(done), 32'd0);

      // Directed corner values, back-to-back.
      convert(0, 0);
      convert(1234, 0);
      convert(9999, 0);
      convert(10000, 0);
      convert(16383, 0);
      convert(5678, 5);
      convert(42, 0);

      // Reset mid-conversion.
      start = 1'b1;
      bin   = 14'd777;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_bcd", 32'(bcd), 32'd0);
      chk("arst_ovf", 32'(ovf), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen_done = 0;
      repeat (16) begin
         @(posedge clk); #1;
         if (done || busy) seen_done++;
      end
      chk("no_done_after_rst", 32'(seen_done), 32'd0);
      convert(777, 0);

      // Random values, weighted toward the 9999/10000 boundary.
      for (int i = 0; i < 3000; i++) begin
         int v;
         if (i % 4 == 0) v = $urandom_range(9980, 10020);
         else            v = $urandom_range(0, 16383);
         convert(v, ((i % 7) == 3) ? int'($urandom_range(1, 13)) : 0);
         if ((i % 10) == 0) begin
            @(posedge clk); #1;
            chk("done_pulse", 32'(done), 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
